// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor.
// Bus width, BTB index width and 2-bit counter encodings.
package branch_predictor_pkg;

  localparam int DataBusBits = 64;
  localparam int BpIdxBits   = 4;

  typedef enum logic [1:0] {
    BpStrongNT = 2'b00,
    BpWeakNT   = 2'b01,
    BpWeakT    = 2'b10,
    BpStrongT  = 2'b11
  } bpCtr_e;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for one 2-bit saturating direction counter.
// Jumps force strong-taken; fresh allocations start weak.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       alloc,
  input  logic       jump,
  output logic [1:0] nextCtr
);

  // jump beats alloc beats the normal saturating step
  always_comb begin
    nextCtr = ctr;
    if (jump) begin
      nextCtr = BpStrongT;
    end else if (alloc) begin
      nextCtr = taken ? BpWeakT : BpWeakNT;
    end else if (taken) begin
      if (ctr != BpStrongT) nextCtr = ctr + 2'd1;
    end else begin
      if (ctr != BpStrongNT) nextCtr = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, predicting next PC in F.
// Learns from resolved control flow in E; keeps perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN     = DataBusBits,
  parameter int IDX_BITS = BpIdxBits,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     PCF,
  output logic [XLEN-1:0]     predPCF,
  output logic                predTakenF,
  input  logic                updateE,
  input  logic                isJumpE,
  input  logic [XLEN-1:0]     PCE,
  input  logic [XLEN-1:0]     targetE,
  input  logic                takenE,
  input  logic                mispredictE,
  output logic [CNT_BITS-1:0] branchCount,
  output logic [CNT_BITS-1:0] mispredictCount
);

  localparam int Entries = 1 << IDX_BITS;
  localparam int TagBits = XLEN - IDX_BITS - 2;

  logic                validQ  [Entries];
  logic [TagBits-1:0]  tagQ    [Entries];
  logic [XLEN-1:0]     targetQ [Entries];
  logic [1:0]          ctrQ    [Entries];

  logic [IDX_BITS-1:0] idxF;
  logic [IDX_BITS-1:0] idxE;
  logic [TagBits-1:0]  tagF;
  logic [TagBits-1:0]  tagE;
  logic                hitF;
  logic                hitE;
  logic [1:0]          nextCtrE;
  logic [3:0]          unusedPcBits;

  assign idxF = PCF[IDX_BITS+1:2];
  assign tagF = PCF[XLEN-1:IDX_BITS+2];
  assign idxE = PCE[IDX_BITS+1:2];
  assign tagE = PCE[XLEN-1:IDX_BITS+2];

  assign unusedPcBits = {PCF[1:0], PCE[1:0]};

  // lookup reads registered state only, so a same-cycle write is not seen
  always_comb begin
    hitF       = validQ[idxF] && (tagQ[idxF] == tagF);
    predTakenF = hitF && ctrQ[idxF][1];
    predPCF    = predTakenF ? targetQ[idxF] : PCF + XLEN'(4);
  end

  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  sat_counter2 uCtr (
    .ctr     (ctrQ[idxE]),
    .taken   (takenE),
    .alloc   (~hitE),
    .jump    (isJumpE),
    .nextCtr (nextCtrE)
  );

  // table write; reset wins over a same-edge update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= BpWeakNT;
      end
    end else if (updateE) begin
      validQ[idxE]  <= 1'b1;
      tagQ[idxE]    <= tagE;
      targetQ[idxE] <= targetE;
      ctrQ[idxE]    <= nextCtrE;
    end
  end

  // perf counters stick at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      branchCount     <= '0;
      mispredictCount <= '0;
    end else if (updateE) begin
      if (branchCount != '1)
        branchCount <= branchCount + 1'b1;
      if (mispredictE && (mispredictCount != '1))
        mispredictCount <= mispredictCount + 1'b1;
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor for the pipelined core.
- Produces the predicted next PC in F. The hazard unit later checks it in E against the resolved PCNextE.
- Learns from resolved branches and jumps reported by E, using a direct-mapped BTB plus 2-bit saturating counters.
- Also keeps branch and mispredict performance counters.

Parameters:
- XLEN, 64, PC/target width; must equal `DataBusBits.
- IDX_BITS, 4, BTB index width; the table has 2^IDX_BITS entries.
- CNT_BITS, 32, performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- PCF  in  XLEN  PC currently in fetch.
- predPCF  out  XLEN  predicted next PC.
- predTakenF  out  1  1 = prediction redirects to BTB target.
- updateE  in  1  E holds a resolved control-flow instruction (BRANCH/JAL/JALR), not flushed.
- isJumpE  in  1  the instruction in E is JAL or JALR (unconditional).
- PCE  in  XLEN  PC of the instruction in E.
- targetE  in  XLEN  resolved taken-target of the instruction in E.
- takenE  in  1  resolved direction (1 for jumps).
- mispredictE  in  1  hazard unit's ~validPrediction for the instruction in E.
- branchCount  out  CNT_BITS  resolved control-flow instructions counted.
- mispredictCount  out  CNT_BITS  mispredictions counted.

Behaviour:
- Table state per entry: valid (1), tag (XLEN-IDX_BITS-2), target (XLEN), ctr (2).
- Addressing: index = PC[IDX_BITS+1:2]; tag = PC[XLEN-1:IDX_BITS+2]. PC[1:0] is ignored.
- Lookup is combinational from registered state, zero latency.
  - hit = valid[idxF] & tag[idxF]==tagF.
  - predTakenF = hit & ctr[idxF][1].
  - predPCF = predTakenF ? target[idxF] : PCF+4.
  - PCF+4 wraps modulo 2^XLEN.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Update: on a clk edge with updateE=1, entry idxE is written.
  - Hit on idxE/tagE, conditional branch: target<=targetE; ctr increments (saturate at 11) if takenE, else decrements (saturate at 00).
  - Miss (invalid or tag mismatch), conditional branch: allocate; valid<=1, tag<=tagE, target<=targetE, ctr<=takenE?10:01.
  - Jump, hit or miss: valid<=1, tag<=tagE, target<=targetE, ctr<=11.
  - updateE=0: no table change. Caller gates updateE with flushE.
- Same-cycle read/write, even at the same index: lookup returns pre-edge contents. No bypass.
- Perf counters: on updateE, branchCount+1. On updateE & mispredictE, mispredictCount+1. Both saturate at all-ones and never wrap.
- mispredictE without updateE is ignored.
- Reset:
  - All valid<=0; all ctr<=01; target/tag cleared to 0.
  - Both perf counters <=0.
  - Outputs after reset: predTakenF=0, predPCF=PCF+4.
  - Reset has priority over a simultaneous update, including reset asserted mid-stream.
- Stalls need no port. While F is stalled PCF is held, so the prediction stays stable unless an E update to the same index lands. Re-prediction then is correct behaviour.

Decomposition:
- Shared header diagv2_const.vh holds:
  - `DataBusBits (already present).
  - New `BpIdxBits.
  - Counter encodings `BpStrongNT / `BpWeakNT / `BpWeakT / `BpStrongT.
- Sub-module sat_counter2: combinational next-state for the 2-bit counter; inputs ctr, taken, alloc, jump; output next ctr.
- Table arrays and perf counters stay in branch_predictor.

Test Plan:
- Reset, then PCF=0x1000 -> predTakenF=0, predPCF=0x1004; both counters 0.
- updateE, branch, PCE=0x1000, targetE=0x0F00, takenE=1 -> next cycle PCF=0x1000 gives predTakenF=1 (ctr 10), predPCF=0x0F00. Then two not-taken updates -> ctr 00, predPCF=0x1004.
- Aliasing: train 0x1000 taken. Lookup PCF=0x1040 (same index, different tag) -> miss, predPCF=0x1044. Then a JAL update at 0x1040 with target 0x2000 -> 0x1040 predicts 0x2000, and 0x1000 now misses.
- Same-cycle: PCF=PCE=0x1000 with first update -> predPCF=0x1004 that cycle, 0x0F00 the next cycle.
- Wrap: PCF=0xFFFF_FFFF_FFFF_FFFC on miss -> predPCF=0.
- Perf: 3 updates, 1 with mispredictE -> branchCount=3, mispredictCount=1. mispredictE alone -> no change. Force branchCount to all-ones -> it stays saturated. Assert reset with updateE=1 -> all state cleared.
